// File: rtl/tpa_pkg.sv
// tpa_pkg: shared types and constants for the
// dual-port config register file.
package tpa_pkg;

  typedef enum logic {
    RIM_IDLE,
    RIM_ACK
  } rim_state_e;

  typedef enum logic [2:0] {
    TWP_IDLE,
    TWP_CMD,
    TWP_ADDR,
    TWP_WDATA,
    TWP_TAR,
    TWP_RSTART,
    TWP_RDATA
  } twp_state_e;

  localparam int unsigned TAR_LEN = 3;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tpa_twp_slave.sv
// tpa_twp_slave: single-wire serial slave FSM,
// shifters and bit counter.
module tpa_twp_slave
  import tpa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_oe_o,
  output logic              start_o,
  output logic              open_o,
  output logic              commit_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              snap_o,
  input  logic [DATA_W-1:0] snap_data_i
);

  localparam int unsigned CW =
    max3(ADDR_W, DATA_W, TAR_LEN);
  localparam int NW = $clog2(CW) + 1;

  localparam logic [NW-1:0] A_LAST =
    NW'(ADDR_W - 1);
  localparam logic [NW-1:0] D_LAST =
    NW'(DATA_W - 1);
  localparam logic [NW-1:0] T_LAST =
    NW'(TAR_LEN - 1);

  twp_state_e        state_q, state_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] shift_q, shift_d;

  // incoming bit joins at the MSB end, so LSB-first
  // frames land in natural order
  logic [ADDR_W:0]   addr_sh;
  logic [DATA_W:0]   data_sh;

  assign addr_sh = {sda_i, addr_q};
  assign data_sh = {sda_i, data_q};
  assign addr_o  = addr_q;
  assign wdata_o = data_sh[DATA_W:1];

  // state, counter and shifter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TWP_IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_RD;
      addr_q  <= '0;
      data_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      shift_q <= shift_d;
    end
  end

  // frame sequencing: next state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    shift_d = shift_q;
    unique case (state_q)
      TWP_IDLE: begin
        if (!sda_i) state_d = TWP_CMD;
      end
      TWP_CMD: begin
        cmd_d   = sda_i;
        cnt_d   = '0;
        state_d = TWP_ADDR;
      end
      TWP_ADDR: begin
        addr_d = addr_sh[ADDR_W:1];
        cnt_d  = cnt_q + NW'(1);
        if (cnt_q == A_LAST) begin
          cnt_d   = '0;
          state_d = (cmd_q == CMD_WR) ?
                    TWP_WDATA : TWP_TAR;
        end
      end
      TWP_WDATA: begin
        data_d = data_sh[DATA_W:1];
        cnt_d  = cnt_q + NW'(1);
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          state_d = TWP_IDLE;
        end
      end
      TWP_TAR: begin
        if (cnt_q == '0) shift_d = snap_data_i;
        cnt_d = cnt_q + NW'(1);
        if (cnt_q == T_LAST) begin
          cnt_d   = '0;
          state_d = TWP_RSTART;
        end
      end
      TWP_RSTART: begin
        cnt_d   = '0;
        state_d = TWP_RDATA;
      end
      TWP_RDATA: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + NW'(1);
        if (cnt_q == D_LAST) begin
          cnt_d   = '0;
          state_d = TWP_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = TWP_IDLE;
      end
    endcase
  end

  // line drive and handshake strobes to the top
  always_comb begin
    sda_o    = 1'b1;
    sda_oe_o = 1'b0;
    start_o  = 1'b0;
    open_o   = 1'b0;
    commit_o = 1'b0;
    snap_o   = 1'b0;
    unique case (state_q)
      TWP_IDLE:  start_o = !sda_i;
      TWP_CMD:   open_o  = 1'b1;
      TWP_ADDR:  open_o  = 1'b1;
      TWP_WDATA: begin
        open_o   = 1'b1;
        commit_o = (cnt_q == D_LAST);
      end
      TWP_TAR: begin
        snap_o   = (cnt_q == '0);
        sda_oe_o = (cnt_q != '0);
      end
      TWP_RSTART: begin
        sda_oe_o = 1'b1;
        sda_o    = 1'b0;
      end
      TWP_RDATA: begin
        sda_oe_o = 1'b1;
        sda_o    = shift_q[0];
      end
      default: sda_oe_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/tpa_param.sv
// tpa_param: register array shared by a parallel
// port and a serial port, with write collision logic.
module tpa_param
  import tpa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sda_in,
  output logic              sda_out,
  output logic              sda_oe,
  input  logic              cfg_req,
  input  logic              cfg_cmd,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_rdy,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              twp_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  rim_state_e        rim_q, rim_d;
  logic              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              par_wr;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  dirty_q;

  logic              t_start;
  logic              t_open;
  logic              t_commit;
  logic              t_snap;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  logic [DATA_W-1:0] t_snap_data;
  logic              drop_hit;
  logic              ser_ok;

  // parallel request capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rim_q   <= RIM_IDLE;
      cmd_q   <= CMD_RD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      rim_q   <= rim_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // parallel FSM: take a request, ack one cycle
  always_comb begin
    rim_d   = rim_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (rim_q)
      RIM_IDLE: begin
        if (cfg_req) begin
          cmd_d   = cfg_cmd;
          addr_d  = cfg_addr;
          wdata_d = cfg_wdata;
          rim_d   = RIM_ACK;
        end
      end
      RIM_ACK: rim_d = RIM_IDLE;
      default: rim_d = RIM_IDLE;
    endcase
  end

  // parallel FSM outputs and write strobe
  always_comb begin
    cfg_rdy   = (rim_q == RIM_ACK);
    cfg_rdata = '0;
    par_wr    = 1'b0;
    if (cfg_rdy) begin
      if (cmd_q == CMD_WR) par_wr = !reset;
      else cfg_rdata = mem_q[addr_q];
    end
  end

  assign t_snap_data =
    t_snap ? mem_q[t_addr] : '0;

  tpa_twp_slave #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_twp (
    .clk_i       (clk),
    .rst_i       (reset),
    .sda_i       (sda_in),
    .sda_o       (sda_out),
    .sda_oe_o    (sda_oe),
    .start_o     (t_start),
    .open_o      (t_open),
    .commit_o    (t_commit),
    .addr_o      (t_addr),
    .wdata_o     (t_wdata),
    .snap_o      (t_snap),
    .snap_data_i (t_snap_data)
  );

  // the serial address is only known at the end of
  // ADDR, so remember every parallel write target
  // seen while the frame is open
  always_ff @(posedge clk) begin
    if (reset || t_start) begin
      dirty_q <= '0;
    end else if (par_wr && t_open) begin
      dirty_q[addr_q] <= 1'b1;
    end
  end

  assign drop_hit = dirty_q[t_addr] ||
    (par_wr && (addr_q == t_addr));
  assign ser_ok   = t_commit && !drop_hit && !reset;
  assign twp_drop = t_commit && drop_hit && !reset;

  // array update; a same-address clash already
  // discarded the serial word, so order is moot
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_VAL;
      end
    end else begin
      if (ser_ok) mem_q[t_addr] <= t_wdata;
      if (par_wr) mem_q[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_tpa_param.sv
// tb_tpa_param: directed bench for tpa_param with
// hand-computed expectations.
module tb_tpa_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        sda_in;
  logic        sda_out;
  logic        sda_oe;
  logic        cfg_req;
  logic        cfg_cmd;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_rdy;
  logic [15:0] cfg_rdata;
  logic        twp_drop;

  int ntests = 0;
  int nfail  = 0;

  tpa_param #(
    .DATA_W  (16),
    .ADDR_W  (8),
    .RST_VAL (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sda_in    (sda_in),
    .sda_out   (sda_out),
    .sda_oe    (sda_oe),
    .cfg_req   (cfg_req),
    .cfg_cmd   (cfg_cmd),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdy   (cfg_rdy),
    .cfg_rdata (cfg_rdata),
    .twp_drop  (twp_drop)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(
    input logic [7:0]  a,
    input logic [15:0] d
  );
    cfg_req   = 1'b1;
    cfg_cmd   = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick;
    cfg_req = 1'b0;
    #1;
    chk("wr_rdy", cfg_rdy, 1);
    tick;
    chk("wr_rdy_low", cfg_rdy, 0);
  endtask

  task automatic cfg_rd(
    input string       tag,
    input logic [7:0]  a,
    input logic [15:0] e
  );
    cfg_req  = 1'b1;
    cfg_cmd  = 1'b0;
    cfg_addr = a;
    tick;
    cfg_req = 1'b0;
    #1;
    chk("rd_rdy", cfg_rdy, 1);
    chk(tag, cfg_rdata, e);
    tick;
  endtask

  // drive a parallel request at frame cycle k
  task automatic inject(
    input int          i,
    input int          k,
    input logic        pcmd,
    input logic [7:0]  pa,
    input logic [15:0] pd
  );
    if (i == k) begin
      cfg_req   = 1'b1;
      cfg_cmd   = pcmd;
      cfg_addr  = pa;
      cfg_wdata = pd;
    end else begin
      cfg_req = 1'b0;
    end
  endtask

  task automatic twp_wr(
    input string       tag,
    input logic [7:0]  a,
    input logic [15:0] d,
    input int          k,
    input logic        pcmd,
    input logic [7:0]  pa,
    input logic [15:0] pd,
    input logic        xdrop
  );
    logic b;
    for (int i = 0; i < 26; i++) begin
      if (i == 0)      b = 1'b0;
      else if (i == 1) b = 1'b1;
      else if (i < 10) b = a[i-2];
      else             b = d[i-10];
      sda_in = b;
      inject(i, k, pcmd, pa, pd);
      #1;
      if (k >= 0 && i == k + 1) begin
        chk("inj_rdy", cfg_rdy, 1);
        if (!pcmd) chk("inj_rdata", cfg_rdata, pd);
      end
      if (i == 25) chk(tag, twp_drop, xdrop);
      tick;
    end
    sda_in  = 1'b1;
    cfg_req = 1'b0;
  endtask

  task automatic twp_rd(
    input string       tag,
    input logic [7:0]  a,
    input logic [15:0] e,
    input int          k,
    input logic [7:0]  pa,
    input logic [15:0] pd
  );
    logic        b;
    logic [15:0] got;
    got = '0;
    for (int i = 0; i < 31; i++) begin
      if (i < 2)       b = 1'b0;
      else if (i < 10) b = a[i-2];
      else             b = 1'b1;
      sda_in = b;
      inject(i, k, 1'b1, pa, pd);
      #1;
      if (k >= 0 && i == k + 1)
        chk("rinj_rdy", cfg_rdy, 1);
      if (i == 10) chk("tar1_oe", sda_oe, 0);
      if (i == 11 || i == 12) begin
        chk("tar_oe", sda_oe, 1);
        chk("tar_out", sda_out, 1);
      end
      if (i == 13) begin
        chk("rst_oe", sda_oe, 1);
        chk("rst_out", sda_out, 0);
      end
      if (i == 14) chk("rd_oe", sda_oe, 1);
      if (i >= 14 && i < 30) got[i-14] = sda_out;
      if (i == 30) chk("rel_oe", sda_oe, 0);
      tick;
    end
    cfg_req = 1'b0;
    chk(tag, got, e);
  endtask

  initial begin
    reset     = 1'b1;
    sda_in    = 1'b1;
    cfg_req   = 1'b0;
    cfg_cmd   = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("rst_rdy", cfg_rdy, 0);
    chk("rst_rdata", cfg_rdata, 0);
    chk("rst_oe", sda_oe, 0);
    chk("rst_out", sda_out, 1);
    chk("rst_drop", twp_drop, 0);

    cfg_wr(8'h10, 16'hA5A5);
    cfg_rd("p_rd10", 8'h10, 16'hA5A5);

    twp_wr("s_wr33", 8'h33, 16'h1234,
           -1, 1'b1, 8'h0, 16'h0, 1'b0);
    twp_rd("s_rd33", 8'h33, 16'h1234,
           -1, 8'h0, 16'h0);

    twp_wr("drop40", 8'h40, 16'h1111,
           5, 1'b1, 8'h40, 16'hBEEF, 1'b1);
    cfg_rd("p_rd40", 8'h40, 16'hBEEF);

    twp_wr("nodrop60", 8'h60, 16'h2222,
           5, 1'b1, 8'h61, 16'h3333, 1'b0);
    cfg_rd("p_rd60", 8'h60, 16'h2222);
    cfg_rd("p_rd61", 8'h61, 16'h3333);

    twp_wr("drop50", 8'h50, 16'h5555,
           24, 1'b1, 8'h50, 16'h6666, 1'b1);
    cfg_rd("p_rd50", 8'h50, 16'h6666);

    twp_wr("same_cyc", 8'h70, 16'h7777,
           24, 1'b1, 8'h71, 16'h7171, 1'b0);
    cfg_rd("p_rd70", 8'h70, 16'h7777);
    cfg_rd("p_rd71", 8'h71, 16'h7171);

    cfg_wr(8'h80, 16'h0A0A);
    twp_wr("old_rd", 8'h80, 16'h0B0B,
           24, 1'b0, 8'h80, 16'h0A0A, 1'b0);
    cfg_rd("p_rd80", 8'h80, 16'h0B0B);

    cfg_wr(8'h20, 16'h0001);
    twp_rd("snap20", 8'h20, 16'h0001,
           16, 8'h20, 16'hFFFF);
    cfg_rd("p_rd20", 8'h20, 16'hFFFF);

    twp_wr("b2b_a", 8'h90, 16'h9999,
           -1, 1'b1, 8'h0, 16'h0, 1'b0);
    twp_wr("b2b_b", 8'h91, 16'h9191,
           -1, 1'b1, 8'h0, 16'h0, 1'b0);
    cfg_rd("p_rd90", 8'h90, 16'h9999);
    cfg_rd("p_rd91", 8'h91, 16'h9191);

    for (int i = 0; i < 15; i++) begin
      if (i == 0)      sda_in = 1'b0;
      else if (i == 1) sda_in = 1'b1;
      else             sda_in = 1'b1;
      tick;
    end
    reset = 1'b1;
    tick;
    reset  = 1'b0;
    sda_in = 1'b1;
    #1;
    chk("abort_oe", sda_oe, 0);
    chk("abort_rdy", cfg_rdy, 0);
    for (int i = 0; i < 14; i++) tick;
    chk("abort_drop", twp_drop, 0);
    cfg_rd("abort_rd10", 8'h10, 16'h0000);
    cfg_rd("abort_rd33", 8'h33, 16'h0000);
    cfg_rd("abort_rdff", 8'hFF, 16'h0000);

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
